// File: rtl/shift_add_mul_seq.sv
`timescale 1ns/1ps
// shift_add_mul_seq: sequential unsigned multiplier. One adder and one
// left-by-1 shifter are reused over WIDTH cycles to build a 2*WIDTH-bit
// product. Operands enter through a valid/ready handshake, and the result
// leaves through a second valid/ready handshake.
module shift_add_mul_seq #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_next_s;
  logic [PW-1:0]   mcand_r;
  logic [PW-1:0]   acc_r;
  logic [PW-1:0]   acc_sum_s;
  logic [WIDTH-1:0] mplr_r;
  logic [CW-1:0]   cnt_r;
  logic            last_s;

  // The final RUN edge is the one where the counter has reached WIDTH-1.
  assign last_s = (cnt_r == CW'(WIDTH - 1));

  // Add the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    acc_sum_s = acc_r;
    if (mplr_r[0]) begin
      acc_sum_s = acc_r + mcand_r;
    end else begin
      acc_sum_s = acc_r;
    end
  end

  // Next-state logic for the IDLE -> RUN -> DONE -> IDLE sequence.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Handshake and status outputs are registered copies of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      in_ready  <= (state_next_s == ST_IDLE);
      out_valid <= (state_next_s == ST_DONE);
      busy      <= (state_next_s == ST_RUN);
    end
  end

  // Shift-add datapath: load on accept, one partial product per RUN edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_r <= {PW{1'b0}};
      mplr_r  <= {WIDTH{1'b0}};
      acc_r   <= {PW{1'b0}};
      cnt_r   <= {CW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            mcand_r <= {{WIDTH{1'b0}}, a};
            mplr_r  <= b;
            acc_r   <= {PW{1'b0}};
            cnt_r   <= {CW{1'b0}};
          end
        end
        ST_RUN: begin
          acc_r   <= acc_sum_s;
          mcand_r <= {mcand_r[PW-2:0], 1'b0};
          mplr_r  <= {1'b0, mplr_r[WIDTH-1:1]};
          cnt_r   <= cnt_r + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Product is captured on the last RUN edge and held until the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      product <= {PW{1'b0}};
    end else if ((state_r == ST_RUN) && last_s) begin
      product <= acc_sum_s;
    end
  end

endmodule

// File: tb/tb_shift_add_mul_seq.sv
`timescale 1ns/1ps
// Directed bench for shift_add_mul_seq with WIDTH=4.
module tb_shift_add_mul_seq;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] product;
  logic       busy;

  int total;
  int bad;
  int acc_cnt;
  int res_cnt;

  shift_add_mul_seq #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count accept and result handshakes mid-cycle, away from the clock edge.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) acc_cnt <= acc_cnt + 1;
    if (!rst && out_valid && out_ready) res_cnt <= res_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair, then wait (bounded) for out_valid.
  // lat = number of edges after the accept edge until out_valid is seen.
  task automatic do_op(input logic [3:0] ta, input logic [3:0] tb,
                       output int lat, output logic [7:0] prod,
                       output logic busy0, output logic rdy0);
    a = ta;
    b = tb;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a = 4'($urandom);
    b = 4'($urandom);
    busy0 = busy;
    rdy0  = in_ready;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    prod = product;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (product !== 8'h00) begin bad++; $display("FAIL reset_product got=%h exp=00", product); end
    rst = 1'b0;
  endtask

  task automatic test_max();
    int lat; logic [7:0] p; logic b0; logic r0;
    out_ready = 1'b1;
    do_op(4'd15, 4'd15, lat, p, b0, r0);
    total++; if (b0 !== 1'b1) begin bad++; $display("FAIL max_busy_run got=%b exp=1", b0); end
    total++; if (r0 !== 1'b0) begin bad++; $display("FAIL max_ready_run got=%b exp=0", r0); end
    total++; if (lat !== 4) begin bad++; $display("FAIL max_latency got=%0d exp=4", lat); end
    total++; if (p !== 8'hE1) begin bad++; $display("FAIL max_product got=%h exp=e1", p); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL max_busy_done got=%b exp=0", busy); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL max_ov_after got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL max_rdy_after got=%b exp=1", in_ready); end
  endtask

  task automatic test_zero();
    int lat; logic [7:0] p; logic b0; logic r0;
    out_ready = 1'b1;
    do_op(4'd0, 4'd9, lat, p, b0, r0);
    total++; if (lat !== 4) begin bad++; $display("FAIL zero_a_latency got=%0d exp=4", lat); end
    total++; if (p !== 8'h00) begin bad++; $display("FAIL zero_a_product got=%h exp=00", p); end
    step();
    do_op(4'd9, 4'd0, lat, p, b0, r0);
    total++; if (lat !== 4) begin bad++; $display("FAIL zero_b_latency got=%0d exp=4", lat); end
    total++; if (p !== 8'h00) begin bad++; $display("FAIL zero_b_product got=%h exp=00", p); end
    step();
  endtask

  task automatic test_stall();
    int lat; logic [7:0] p; logic b0; logic r0;
    out_ready = 1'b0;
    do_op(4'd6, 4'd7, lat, p, b0, r0);
    total++; if (p !== 8'd42) begin bad++; $display("FAIL stall_product got=%0d exp=42", p); end
    for (int i = 0; i < 10; i++) begin
      step();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_ov_hold cyc=%0d got=%b exp=1", i, out_valid); end
      total++; if (product !== 8'd42) begin bad++; $display("FAIL stall_prod_hold cyc=%0d got=%0d exp=42", i, product); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_rdy cyc=%0d got=%b exp=0", i, in_ready); end
    end
    out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_release_ov got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_release_rdy got=%b exp=1", in_ready); end
  endtask

  task automatic test_reset_abort();
    int lat; logic [7:0] p; logic b0; logic r0;
    out_ready = 1'b1;
    a = 4'd13;
    b = 4'd11;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL abort_rdy got=%b exp=1", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    total++; if (product !== 8'h00) begin bad++; $display("FAIL abort_product got=%h exp=00", product); end
    for (int i = 0; i < 6; i++) begin
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_ov cyc=%0d got=%b exp=0", i, out_valid); end
      step();
    end
    do_op(4'd3, 4'd5, lat, p, b0, r0);
    total++; if (lat !== 4) begin bad++; $display("FAIL abort_next_latency got=%0d exp=4", lat); end
    total++; if (p !== 8'd15) begin bad++; $display("FAIL abort_next_product got=%0d exp=15", p); end
    step();
  endtask

  task automatic test_in_valid_during_run();
    int lat; int acc0;
    acc0 = acc_cnt;
    out_ready = 1'b1;
    a = 4'd10;
    b = 4'd12;
    in_valid = 1'b1;
    step();
    lat = 0;
    in_valid = 1'b0;
    step();
    lat++;
    a = 4'd1;
    b = 4'd1;
    in_valid = 1'b1;
    step();
    lat++;
    in_valid = 1'b0;
    while (out_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    total++; if (lat !== 4) begin bad++; $display("FAIL ivrun_latency got=%0d exp=4", lat); end
    total++; if (product !== 8'd120) begin bad++; $display("FAIL ivrun_product got=%0d exp=120", product); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ivrun_ov_after got=%b exp=0", out_valid); end
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ivrun_no_second_op got=%b exp=0", busy); end
    total++; if (acc_cnt - acc0 !== 1) begin bad++; $display("FAIL ivrun_accepts got=%0d exp=1", acc_cnt - acc0); end
  endtask

  task automatic test_exhaustive();
    int lat; logic [7:0] p; logic b0; logic r0;
    logic [3:0] ta; logic [3:0] tb;
    logic [7:0] exp_p;
    int acc0; int res0;
    acc0 = acc_cnt;
    res0 = res_cnt;
    for (int i = 0; i < 256; i++) begin
      ta = i[7:4];
      tb = i[3:0];
      exp_p = {4'd0, ta} * {4'd0, tb};
      repeat ($urandom_range(0, 2)) step();
      out_ready = 1'($urandom_range(0, 1));
      do_op(ta, tb, lat, p, b0, r0);
      total++; if (p !== exp_p) begin bad++; $display("FAIL exh_product a=%0d b=%0d got=%0d exp=%0d", ta, tb, p, exp_p); end
      total++; if (lat !== 4) begin bad++; $display("FAIL exh_latency a=%0d b=%0d got=%0d exp=4", ta, tb, lat); end
      if (out_ready == 1'b0) begin
        repeat ($urandom_range(0, 3)) step();
        out_ready = 1'b1;
      end
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL exh_ov_after a=%0d b=%0d got=%b exp=0", ta, tb, out_valid); end
    end
    step();
    total++; if (acc_cnt - acc0 !== 256) begin bad++; $display("FAIL exh_accepts got=%0d exp=256", acc_cnt - acc0); end
    total++; if (res_cnt - res0 !== 256) begin bad++; $display("FAIL exh_results got=%0d exp=256", res_cnt - res0); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    acc_cnt = 0;
    res_cnt = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = 4'd0;
    b = 4'd0;
    test_reset();
    test_max();
    test_zero();
    test_stall();
    test_reset_abort();
    test_in_valid_during_run();
    test_exhaustive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
